// File: rtl/start_requester_if.sv
// Handshake/data bundle between the start_requester (master) and its user/datapath side (slave).
interface start_requester_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              req;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] data_in;
    logic              fin;
    logic              xs;
    logic [DATA_W-1:0] oper;
    logic [DATA_W-1:0] result;
    logic              valid;
    logic              busy;
    logic              timeout;
    logic [CNT_W-1:0]  jobs;

    modport master (
        input  req, op_a, data_in, fin,
        output xs, oper, result, valid, busy, timeout, jobs
    );

    modport slave (
        output req, op_a, data_in, fin,
        input  xs, oper, result, valid, busy, timeout, jobs
    );
endinterface

// File: rtl/start_requester.sv
// Initiator side of the xs/fin start-done handshake with result capture and WAIT timeout.
// Optional START_REQ_PENDING_EN: remembers one request edge seen while busy and launches it from IDLE.
module start_requester #(
    parameter int DATA_W         = 8,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic               clk,
    input logic               reset,
    start_requester_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    state_t            state, next_state;
    logic              req_q;
    logic              req_edge;
    logic              start;
    logic [CW-1:0]     wait_cnt;
    logic [DATA_W-1:0] oper_r;
    logic [DATA_W-1:0] result_r;
    logic [CNT_W-1:0]  jobs_r;
    logic              timeout_r;
    logic              xs_c, valid_c, busy_c;

    assign req_edge = bus.req & ~req_q;

`ifdef START_REQ_PENDING_EN
    logic pending;

    // A single remembered edge; any further edges while busy collapse into it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= 1'b0;
        else if (state == IDLE)
            pending <= 1'b0;
        else if (req_edge)
            pending <= 1'b1;
    end

    assign start = req_edge | pending;
`else
    assign start = req_edge;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        xs_c       = 1'b0;
        valid_c    = 1'b0;
        busy_c     = (state != IDLE);
        case (state)
            IDLE:    if (start) next_state = LAUNCH;
            LAUNCH: begin
                xs_c       = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                // fin takes priority over expiry on the final WAIT cycle.
                if (bus.fin)
                    next_state = CAPTURE;
                else if (wait_cnt == LAST_CNT)
                    next_state = RELEASE;
            end
            CAPTURE: begin
                valid_c    = 1'b1;
                next_state = RELEASE;
            end
            RELEASE: if (!bus.fin) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // req_q resets high so a request held through reset is not seen as a new edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= 1'b1;
            oper_r    <= '0;
            result_r  <= '0;
            jobs_r    <= '0;
            timeout_r <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            req_q <= bus.req;
            case (state)
                IDLE: begin
                    if (start) begin
                        oper_r    <= bus.op_a;
                        timeout_r <= 1'b0;
                    end
                end
                LAUNCH: wait_cnt <= '0;
                WAIT: begin
                    if (bus.fin) begin
                        result_r <= bus.data_in;
                        jobs_r   <= jobs_r + 1'b1;
                    end else if (wait_cnt == LAST_CNT) begin
                        timeout_r <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.xs      = xs_c;
    assign bus.valid   = valid_c;
    assign bus.busy    = busy_c;
    assign bus.oper    = oper_r;
    assign bus.result  = result_r;
    assign bus.jobs    = jobs_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_start_requester.sv
// Self-checking bench for start_requester: scoreboard of expected result/jobs popped on each valid pulse.
// Build with +define+START_REQ_PENDING_EN to exercise the pending-request variant.
module tb_start_requester;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 16;
    localparam int JOB_MOD = 1 << CNT_W;

    typedef struct {
        logic [DATA_W-1:0] res;
        int                jobs;
    } exp_t;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    int   exp_jobs;
    logic [DATA_W-1:0] last_result;
    exp_t sb[$];

    start_requester_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    start_requester #(
        .DATA_W(DATA_W),
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Every valid pulse must match the oldest outstanding expected completion.
    always @(negedge clk) begin
        if (!reset && bus.valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("valid_unexpected", 32'(bus.valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_result", 32'(bus.result), 32'(e.res));
                checkOutput("sb_jobs", 32'(bus.jobs), 32'(e.jobs));
            end
        end
    end

    task automatic waitIdle(input string tag);
        for (int n = 0; n < 8 && bus.busy; n++) @(negedge clk);
        checkOutput(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] op, input logic [DATA_W-1:0] data,
                                 input int fin_delay, input int fin_len, input bit req_in_release);
        @(negedge clk);
        bus.req  = 1'b1;
        bus.op_a = op;
        @(negedge clk);
        checkOutput("xs_launch", 32'(bus.xs), 32'd1);
        checkOutput("oper", 32'(bus.oper), 32'(op));
        checkOutput("timeout_cleared", 32'(bus.timeout), 32'd0);
        bus.req = 1'b0;
        @(negedge clk);
        checkOutput("xs_one_cycle", 32'(bus.xs), 32'd0);
        repeat (fin_delay - 1) @(negedge clk);
        bus.fin     = 1'b1;
        bus.data_in = data;
        exp_jobs    = (exp_jobs + 1) % JOB_MOD;
        sb.push_back('{res: data, jobs: exp_jobs});
        last_result = data;
        for (int i = 0; i < fin_len; i++) begin
            @(negedge clk);
            if (req_in_release && i == 4) bus.req = 1'b1;
            if (req_in_release && i == 5) bus.req = 1'b0;
        end
        checkOutput("busy_fin_high", 32'(bus.busy), 32'd1);
        bus.fin = 1'b0;
        waitIdle("busy_release");
        if (req_in_release) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checkOutput("release_req_dropped", 32'(bus.busy), 32'd0);
            end
        end
    endtask

    initial begin
        int n;
        clk = 1'b0;
        compared = 0;
        mismatched = 0;
        exp_jobs = 0;
        last_result = '0;
        bus.req = 1'b0;
        bus.op_a = '0;
        bus.data_in = '0;
        bus.fin = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        checkOutput("rst_xs", 32'(bus.xs), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_valid", 32'(bus.valid), 32'd0);
        checkOutput("rst_oper", 32'(bus.oper), 32'd0);
        checkOutput("rst_result", 32'(bus.result), 32'd0);
        checkOutput("rst_jobs", 32'(bus.jobs), 32'd0);
        checkOutput("rst_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] normal job");
        applyStimulus(8'h2A, 8'h55, 5, 1, 1'b0);
        checkOutput("normal_result", 32'(bus.result), 32'h55);
        checkOutput("normal_timeout", 32'(bus.timeout), 32'd0);

        $display("[TB] timeout");
        @(negedge clk);
        bus.req  = 1'b1;
        bus.op_a = 8'h11;
        @(negedge clk);
        checkOutput("to_xs", 32'(bus.xs), 32'd1);
        bus.req = 1'b0;
        n = 0;
        while (!bus.timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_wait_cycles", 32'(n), 32'(TIMEOUT + 1));
        checkOutput("to_jobs", 32'(bus.jobs), 32'(exp_jobs));
        checkOutput("to_result", 32'(bus.result), 32'(last_result));
        @(negedge clk);
        checkOutput("to_idle", 32'(bus.busy), 32'd0);
        checkOutput("to_sticky", 32'(bus.timeout), 32'd1);

        $display("[TB] job after timeout");
        applyStimulus(8'h3C, 8'h99, 3, 1, 1'b0);

        $display("[TB] fin as level");
`ifdef START_REQ_PENDING_EN
        applyStimulus(8'h0F, 8'hA5, 2, 10, 1'b0);
`else
        applyStimulus(8'h0F, 8'hA5, 2, 10, 1'b1);
`endif
        checkOutput("level_jobs", 32'(bus.jobs), 32'(exp_jobs));

        $display("[TB] reset mid-WAIT");
        @(negedge clk);
        bus.req  = 1'b1;
        bus.op_a = 8'h44;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_busy_before", 32'(bus.busy), 32'd1);
        bus.req = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_xs", 32'(bus.xs), 32'd0);
        checkOutput("mid_valid", 32'(bus.valid), 32'd0);
        checkOutput("mid_jobs", 32'(bus.jobs), 32'd0);
        checkOutput("mid_oper", 32'(bus.oper), 32'd0);
        exp_jobs = 0;
        last_result = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("held_req_no_launch", 32'(bus.busy), 32'd0);
        end
        bus.req = 1'b0;

        $display("[TB] job counter wrap");
        for (int i = 0; i < 5; i++)
            applyStimulus(DATA_W'($urandom), DATA_W'($urandom), $urandom_range(1, 4), 1, 1'b0);
        checkOutput("wrap_jobs", 32'(bus.jobs), 32'd1);

`ifdef START_REQ_PENDING_EN
        $display("[TB] pending request");
        @(negedge clk);
        bus.req  = 1'b1;
        bus.op_a = 8'h21;
        @(negedge clk);
        checkOutput("pend_xs1", 32'(bus.xs), 32'd1);
        bus.req = 1'b0;
        @(negedge clk); bus.req = 1'b1;
        @(negedge clk); bus.req = 1'b0;
        @(negedge clk); bus.req = 1'b1;
        @(negedge clk); bus.req = 1'b0;
        @(negedge clk);
        bus.fin     = 1'b1;
        bus.data_in = 8'h66;
        exp_jobs    = (exp_jobs + 1) % JOB_MOD;
        sb.push_back('{res: 8'h66, jobs: exp_jobs});
        @(negedge clk);
        bus.fin = 1'b0;
        waitIdle("pend_idle");
        bus.op_a = 8'h77;
        @(negedge clk);
        checkOutput("pend_xs2", 32'(bus.xs), 32'd1);
        checkOutput("pend_oper", 32'(bus.oper), 32'h77);
        @(negedge clk);
        bus.fin     = 1'b1;
        bus.data_in = 8'h88;
        exp_jobs    = (exp_jobs + 1) % JOB_MOD;
        sb.push_back('{res: 8'h88, jobs: exp_jobs});
        @(negedge clk);
        bus.fin = 1'b0;
        waitIdle("pend_idle2");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("pend_single_extra", 32'(bus.xs), 32'd0);
        end
`endif

        repeat (2) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
